// File: rtl/fetch_sequencer.sv
// Fetch front end for a 2-cycle instruction memory: owns the PC, tracks the two in-flight
// slots, and applies stage-2 backpressure and branch redirects.
module fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_PC    = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  out_ready,
  input  logic [31:0]           imem_instruction,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_stall,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [31:0]           out_instruction,
  output logic [31:0]           fetch_count
);

  localparam int unsigned COUNT_WIDTH = 32;

  logic [ADDR_WIDTH-1:0]  pc, pc_next;
  logic                   v0, v0_next;
  logic [ADDR_WIDTH-1:0]  pc0, pc0_next;
  logic                   v1, v1_next;
  logic [ADDR_WIDTH-1:0]  pc1, pc1_next;
  logic [COUNT_WIDTH-1:0] count_q, count_next;

  logic                  hold;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] target;

  // Word-align the redirect target by masking rather than slicing.
  assign target    = redirect_pc & ~ADDR_WIDTH'(3);
  assign hold      = v1 & ~out_ready & ~redirect_valid;
  assign handshake = v1 & out_ready & ~redirect_valid;

  assign imem_stall      = hold;
  assign out_valid       = v1;
  assign out_pc          = pc1;
  assign out_instruction = imem_instruction;
  assign fetch_count     = count_q;

  // On hold the delay register resamples pc0 so the word it holds stays consistent.
  always_comb begin
    imem_addr = pc;
    if (redirect_valid) begin
      imem_addr = target;
    end else if (hold) begin
      imem_addr = pc0;
    end
  end

  // Next-state: redirect beats hold beats advance.
  always_comb begin
    pc_next    = pc;
    v0_next    = v0;
    pc0_next   = pc0;
    v1_next    = v1;
    pc1_next   = pc1;
    count_next = count_q + COUNT_WIDTH'(handshake);
    if (redirect_valid) begin
      v1_next  = 1'b0;
      v0_next  = 1'b1;
      pc0_next = target;
      pc_next  = target + ADDR_WIDTH'(4);
    end else if (!hold) begin
      v1_next  = v0;
      pc1_next = pc0;
      v0_next  = run;
      pc0_next = pc;
      if (run) begin
        pc_next = pc + ADDR_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc      <= BOOT_PC;
      v0      <= 1'b0;
      pc0     <= '0;
      v1      <= 1'b0;
      pc1     <= '0;
      count_q <= '0;
    end else begin
      pc      <= pc_next;
      v0      <= v0_next;
      pc0     <= pc0_next;
      v1      <= v1_next;
      pc1     <= pc1_next;
      count_q <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 2-cycle memory model whose word k holds value k.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic        run;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic [31:0] imem_instruction;
  logic [31:0] imem_addr;
  logic        imem_stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [31:0] fetch_count;

  int vectors;
  int miscompares;

  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;

  fetch_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .run              (run),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_ready        (out_ready),
    .imem_instruction (imem_instruction),
    .imem_addr        (imem_addr),
    .imem_stall       (imem_stall),
    .out_valid        (out_valid),
    .out_pc           (out_pc),
    .out_instruction  (out_instruction),
    .fetch_count      (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: address register samples every edge, output register loads unless stalled.
  always @(posedge clock) begin
    mem_addr_q <= imem_addr;
    if (!imem_stall) mem_data_q <= mem_addr_q >> 2;
  end
  assign imem_instruction = mem_data_q;

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    run = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick; tick;
    vectors++;
    if ({out_valid, imem_stall, fetch_count, imem_addr} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b st=%b cnt=%h addr=%h required 0 0 0 0", out_valid, imem_stall, fetch_count, imem_addr);
    end
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL release_issue: got v=%b addr=%h required v=0 addr=0", out_valid, imem_addr);
    end
    tick;
    vectors++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h4}) begin
      miscompares++;
      $display("FAIL first_latency: got v=%b addr=%h required v=0 addr=4", out_valid, imem_addr);
    end
  endtask

  // Leaves the stream showing out_pc=0x10.
  task automatic test_stream;
    for (int i = 0; i < 5; i++) begin
      tick;
      vectors++;
      if ({out_valid, out_pc, out_instruction, fetch_count} !== {1'b1, 32'(4 * i), 32'(i), 32'(i)}) begin
        miscompares++;
        $display("FAIL stream[%0d]: got v=%b pc=%h ins=%h cnt=%0d required v=1 pc=%h ins=%h cnt=%0d",
                 i, out_valid, out_pc, out_instruction, fetch_count, 4 * i, i, i);
      end
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      vectors++;
      if ({imem_stall, out_valid, out_pc, out_instruction, fetch_count, imem_addr} !==
          {1'b1, 1'b1, 32'h10, 32'd4, 32'd4, 32'h14}) begin
        miscompares++;
        $display("FAIL hold[%0d]: got st=%b v=%b pc=%h ins=%h cnt=%0d addr=%h required 1 1 10 4 4 14",
                 i, imem_stall, out_valid, out_pc, out_instruction, fetch_count, imem_addr);
      end
      tick;
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({imem_stall, out_valid, out_pc, out_instruction, fetch_count} !==
          {1'b0, 1'b1, 32'(32'h10 + 4 * i), 32'(4 + i), 32'(4 + i)}) begin
        miscompares++;
        $display("FAIL release[%0d]: got st=%b v=%b pc=%h ins=%h cnt=%0d required st=0 v=1 pc=%h ins=%h cnt=%0d",
                 i, imem_stall, out_valid, out_pc, out_instruction, fetch_count, 32'h10 + 4 * i, 4 + i, 4 + i);
      end
      tick;
    end
  endtask

  // Entered showing out_pc=0x1C.
  task automatic test_redirect;
    tick;
    drive(1'b1, 1'b1, 1'b1, 32'h40);
    vectors++;
    if ({imem_stall, out_pc, imem_addr, fetch_count} !== {1'b0, 32'h20, 32'h40, 32'd8}) begin
      miscompares++;
      $display("FAIL redirect_issue: got st=%b pc=%h addr=%h cnt=%0d required 0 20 40 8", imem_stall, out_pc, imem_addr, fetch_count);
    end
    tick;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if ({out_valid, fetch_count} !== {1'b0, 32'd8}) begin
      miscompares++;
      $display("FAIL redirect_squash: got v=%b cnt=%0d required v=0 cnt=8", out_valid, fetch_count);
    end
    tick;
    vectors++;
    if ({out_valid, out_pc, out_instruction, fetch_count} !== {1'b1, 32'h40, 32'h10, 32'd8}) begin
      miscompares++;
      $display("FAIL redirect_target: got v=%b pc=%h ins=%h cnt=%0d required 1 40 10 8", out_valid, out_pc, out_instruction, fetch_count);
    end
    tick;
    vectors++;
    if ({out_valid, out_pc, out_instruction, fetch_count} !== {1'b1, 32'h44, 32'h11, 32'd9}) begin
      miscompares++;
      $display("FAIL redirect_next: got v=%b pc=%h ins=%h cnt=%0d required 1 44 11 9", out_valid, out_pc, out_instruction, fetch_count);
    end
  endtask

  task automatic test_redirect_in_hold;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    vectors++;
    if ({imem_stall, out_pc, fetch_count} !== {1'b1, 32'h44, 32'd9}) begin
      miscompares++;
      $display("FAIL hold_before_redirect: got st=%b pc=%h cnt=%0d required 1 44 9", imem_stall, out_pc, fetch_count);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h83);
    vectors++;
    if ({imem_stall, imem_addr} !== {1'b0, 32'h80}) begin
      miscompares++;
      $display("FAIL hold_redirect_addr: got st=%b addr=%h required st=0 addr=80", imem_stall, imem_addr);
    end
    tick;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if ({out_valid, fetch_count} !== {1'b0, 32'd9}) begin
      miscompares++;
      $display("FAIL hold_redirect_drop: got v=%b cnt=%0d required v=0 cnt=9", out_valid, fetch_count);
    end
    tick;
    vectors++;
    if ({out_valid, out_pc, out_instruction, fetch_count} !== {1'b1, 32'h80, 32'h20, 32'd9}) begin
      miscompares++;
      $display("FAIL hold_redirect_target: got v=%b pc=%h ins=%h cnt=%0d required 1 80 20 9", out_valid, out_pc, out_instruction, fetch_count);
    end
    tick;
    vectors++;
    if ({out_valid, out_pc, fetch_count} !== {1'b1, 32'h84, 32'd10}) begin
      miscompares++;
      $display("FAIL hold_redirect_next: got v=%b pc=%h cnt=%0d required 1 84 10", out_valid, out_pc, fetch_count);
    end
  endtask

  task automatic test_run_pause;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick;
    vectors++;
    if ({out_valid, out_pc, out_instruction, fetch_count} !== {1'b1, 32'h88, 32'h22, 32'd11}) begin
      miscompares++;
      $display("FAIL drain: got v=%b pc=%h ins=%h cnt=%0d required 1 88 22 11", out_valid, out_pc, out_instruction, fetch_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      vectors++;
      if ({out_valid, fetch_count} !== {1'b0, 32'd12}) begin
        miscompares++;
        $display("FAIL drained[%0d]: got v=%b cnt=%0d required v=0 cnt=12", i, out_valid, fetch_count);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    vectors++;
    if (imem_addr !== 32'h8C) begin
      miscompares++;
      $display("FAIL resume_addr: got %h required 8c", imem_addr);
    end
    tick;
    tick;
    vectors++;
    if ({out_valid, out_pc, out_instruction, fetch_count} !== {1'b1, 32'h8C, 32'h23, 32'd12}) begin
      miscompares++;
      $display("FAIL resume_out: got v=%b pc=%h ins=%h cnt=%0d required 1 8c 23 12", out_valid, out_pc, out_instruction, fetch_count);
    end
  endtask

  task automatic test_wrap;
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    tick;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick;
    vectors++;
    if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF}) begin
      miscompares++;
      $display("FAIL wrap_top: got v=%b pc=%h ins=%h required 1 fffffffc 3fffffff", out_valid, out_pc, out_instruction);
    end
    tick;
    vectors++;
    if ({out_valid, out_pc, out_instruction} !== {1'b1, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL wrap_zero: got v=%b pc=%h ins=%h required 1 0 0", out_valid, out_pc, out_instruction);
    end
  endtask

  task automatic test_reset_mid_stream;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    vectors++;
    if ({out_valid, imem_stall, fetch_count} !== {1'b0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b st=%b cnt=%0d required 0 0 0", out_valid, imem_stall, fetch_count);
    end
    tick;
    tick;
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick;
    tick;
    vectors++;
    if ({out_valid, out_pc, out_instruction, fetch_count} !== {1'b1, 32'h0, 32'h0, 32'd0}) begin
      miscompares++;
      $display("FAIL reboot: got v=%b pc=%h ins=%h cnt=%0d required 1 0 0 0", out_valid, out_pc, out_instruction, fetch_count);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    run = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect;
    test_redirect_in_hold;
    test_run_pause;
    test_wrap;
    test_reset_mid_stream;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
